user_ip_gpio_ctrl: RTL and testbench
====================================

// Module: user_ip_gpio_ctrl
// PURPOSE
//  Parametrised APB4-mapped GPIO controller: next-gen user IP slot with per-pin direction,
//  output set/clear, 2-flop input sync, rise/fall edge interrupts (W1C), optional debounce.
//  Sits in a user IP slot behind the SoC APB4 fabric; drives pads and raises one level IRQ.
// PARAMETERS
//  ID        8'd255  slot identifier, returned in ID register
//  GPIO_NUM  8       pin count, legal 1..32; register bits [31:GPIO_NUM] read 0, writes ignored
//  DBNC_W    16      debounce counter width (used only with USER_IP_GPIO_DEBOUNCE_EN)
// PORTS
//  clk_i       in   1         single clock
//  rst_i       in   1         reset, asynchronous, active-high
//  apb         if   apb4_if.slave  psel/penable/pwrite/paddr/pwdata in; prdata[31:0]/pready/pslverr out
//  gpio_in_i   in   GPIO_NUM  raw pad inputs, asynchronous to clk_i
//  gpio_out_o  out  GPIO_NUM  pad output data
//  gpio_oen_o  out  GPIO_NUM  pad output enable, active low (0 = drive)
//  irq_o       out  1         level interrupt = |(STAT)
// BEHAVIOUR
//  Reset values: all registers 0, gpio_out_o=0, gpio_oen_o='1 (all inputs), irq_o=0, prdata=0.
//  APB: wr = psel&penable&pwrite, rd = psel&penable&~pwrite; pready=1 (zero wait), pslverr=0.
//  Writes take effect on the clock edge of the access phase; prdata combinational, 0 when no rd.
//  Map (paddr[7:0]); unmapped reads 0, writes dropped:
//   0x00 ID    RO  {24'd0, ID}
//   0x04 DIR   RW  1=output; gpio_oen_o = ~DIR
//   0x08 OUT   RW  gpio_out_o = OUT
//   0x0C SET   WO  OUT |= pwdata; reads 0
//   0x10 CLR   WO  OUT &= ~pwdata; reads 0
//   0x14 IN    RO  synchronised (filtered when debounce on) pin value
//   0x18 RISE  RW  per-pin rising-edge irq enable
//   0x1C FALL  RW  per-pin falling-edge irq enable
//   0x20 STAT  W1C sticky edge status; write 1 clears, write 0 no effect
//   0x24 DBNC  RW  debounce threshold [DBNC_W-1:0] (macro only)
//  Input path: s1<=pin, s2<=s1, prev<=s2; IN=s2; rise=s2&~prev, fall=~s2&prev.
//  Latency: pin change before edge k -> IN shows it after edge k+1 -> STAT bit set at edge k+2
//   (if enabled) -> irq_o high same cycle as STAT (combinational OR of STAT).
//  STAT[i] set when (rise[i]&RISE[i]) | (fall[i]&FALL[i]); set wins over same-cycle W1C clear.
//  Disabling RISE/FALL does not clear STAT; STAT only cleared by W1C or reset.
//  Output pins reading back: IN reflects pad value regardless of DIR (loopback via pad).
//  Pin change of width < 1 clk may be missed; no glitch filtering without macro.
//  Reset mid-operation: all state incl. sync flops and debounce counters clear asynchronously;
//   prev resets 0, so a pin high at reset-exit produces a rise event only if RISE enabled.
// CONFIGURATION
//  USER_IP_GPIO_DEBOUNCE_EN defined: per-pin counter cnt[i] (DBNC_W bits) and filtered flop f[i].
//   s2[i]==f[i] -> cnt<=0; else cnt++ ; when cnt==DBNC then f<=s2, cnt<=0. IN and edge logic use f
//   (prev tracks f). DBNC=0 -> f follows s2 one cycle later (+1 cycle latency vs. macro off).
//   Threshold change takes effect next cycle; counters not cleared by DBNC write.
//  Not defined: no counters/f; IN/edges use s2; DBNC reads 0, writes ignored.
// TESTING
//  1 Reset: read 0x00 -> 0x000000FF; 0x04/0x08/0x20 read 0; gpio_oen_o='1, irq_o=0.
//  2 Write DIR=0xF0, OUT=0xA5, SET=0x02, CLR=0x80 -> gpio_oen_o=0x0F, gpio_out_o=0x27, 0x0C reads 0.
//  3 RISE=0x01, drive pin0 0->1 before edge k -> IN[0]=1 after k+1, STAT=0x01 and irq_o=1 at k+2;
//    write STAT=0x01 -> irq_o=0 next cycle.
//  4 FALL=0x04, pin2 falls in same cycle as W1C STAT=0x04 targets it -> STAT[2] stays 1.
//  5 Assert rst_i mid-edge-sequence with STAT=0x03 -> STAT, irq_o, gpio_out_o zero immediately.
//  6 (macro) DBNC=3, pin1 glitch of 2 clks -> IN[1] unchanged, no STAT; held 5 clks -> IN[1]=1.

Source files
------------

// File: rtl/user_ip_gpio_ctrl.sv
// ----------------------------------------------------------------------------
// user_ip_gpio_ctrl
//   APB4-mapped GPIO controller for a user IP slot. It provides per-pin
//   direction, output data with set/clear aliases, a 2-flop input
//   synchroniser, and rise/fall edge interrupts with sticky write-1-to-clear
//   status. A single level interrupt is the OR of the status bits.
//
//   Optional feature: define USER_IP_GPIO_DEBOUNCE_EN to add a per-pin
//   debounce filter (counter + filtered flop) with a programmable threshold
//   register. Without the macro, IN and the edge detectors use the
//   synchroniser output directly, and DBNC reads 0.
//
// Ports
//   clk_i       in   1         single clock
//   rst_i       in   1         asynchronous active-high reset
//   psel_i      in   1         APB select
//   penable_i   in   1         APB enable (access phase)
//   pwrite_i    in   1         APB direction, 1 = write
//   paddr_i     in   8         APB byte address (register offset)
//   pwdata_i    in   32        APB write data
//   prdata_o    out  32        APB read data, 0 outside a read access
//   pready_o    out  1         always 1 (zero wait states)
//   pslverr_o   out  1         always 0
//   gpio_in_i   in   GPIO_NUM  raw pad inputs, asynchronous to clk_i
//   gpio_out_o  out  GPIO_NUM  pad output data
//   gpio_oen_o  out  GPIO_NUM  pad output enable, active low
//   irq_o       out  1         level interrupt, |STAT
// ----------------------------------------------------------------------------
module user_ip_gpio_ctrl #(
    parameter logic [7:0] ID       = 8'd255,
    parameter int         GPIO_NUM = 8,
    parameter int         DBNC_W   = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                psel_i,
    input  logic                penable_i,
    input  logic                pwrite_i,
    input  logic [7:0]          paddr_i,
    input  logic [31:0]         pwdata_i,
    output logic [31:0]         prdata_o,
    output logic                pready_o,
    output logic                pslverr_o,
    input  logic [GPIO_NUM-1:0] gpio_in_i,
    output logic [GPIO_NUM-1:0] gpio_out_o,
    output logic [GPIO_NUM-1:0] gpio_oen_o,
    output logic                irq_o
);

    localparam logic [7:0] A_ID   = 8'h00;
    localparam logic [7:0] A_DIR  = 8'h04;
    localparam logic [7:0] A_OUT  = 8'h08;
    localparam logic [7:0] A_SET  = 8'h0C;
    localparam logic [7:0] A_CLR  = 8'h10;
    localparam logic [7:0] A_IN   = 8'h14;
    localparam logic [7:0] A_RISE = 8'h18;
    localparam logic [7:0] A_FALL = 8'h1C;
    localparam logic [7:0] A_STAT = 8'h20;
    localparam logic [7:0] A_DBNC = 8'h24;

    // Zero-extend a pin-wide vector onto the 32-bit bus; works for GPIO_NUM=32.
    function automatic logic [31:0] zext(input logic [GPIO_NUM-1:0] v);
        logic [31:0] r;
        r = '0;
        r[GPIO_NUM-1:0] = v;
        return r;
    endfunction

    logic wr, rd;
    logic [GPIO_NUM-1:0] wdata;

    logic [GPIO_NUM-1:0] dir_q, dir_d;
    logic [GPIO_NUM-1:0] out_q, out_d;
    logic [GPIO_NUM-1:0] rise_q, rise_d;
    logic [GPIO_NUM-1:0] fall_q, fall_d;
    logic [GPIO_NUM-1:0] stat_q, stat_d;
    logic [GPIO_NUM-1:0] s1_q, s2_q, prev_q;
    logic [GPIO_NUM-1:0] pin_val;      // value seen by IN and the edge detectors
    logic [GPIO_NUM-1:0] ev_set;

    // Bus bits above the pin count (and upper address bits) are intentionally
    // ignored; fold them into one named sink so the intent is explicit.
    logic unused_bus;
    assign unused_bus = ^pwdata_i;

    assign wr    = psel_i & penable_i & pwrite_i;
    assign rd    = psel_i & penable_i & ~pwrite_i;
    assign wdata = pwdata_i[GPIO_NUM-1:0];

    assign pready_o   = 1'b1;
    assign pslverr_o  = 1'b0;
    assign gpio_out_o = out_q;
    assign gpio_oen_o = ~dir_q;
    assign irq_o      = |stat_q;

    // ------------------------------------------------------------------
    // Optional debounce filter between the synchroniser and IN/edges
    // ------------------------------------------------------------------
`ifdef USER_IP_GPIO_DEBOUNCE_EN
    logic [DBNC_W-1:0]   dbnc_q, dbnc_d;
    logic [GPIO_NUM-1:0] f_q;
    logic [DBNC_W-1:0]   cnt_q [GPIO_NUM];

    // Counter runs while the synchronised pin disagrees with the filtered
    // value; the filter adopts the new value once the count reaches DBNC.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            f_q <= '0;
            for (int i = 0; i < GPIO_NUM; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < GPIO_NUM; i++) begin
                if (s2_q[i] == f_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == dbnc_q) begin
                    f_q[i]   <= s2_q[i];
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        dbnc_d = dbnc_q;
        if (wr && paddr_i == A_DBNC) dbnc_d = pwdata_i[DBNC_W-1:0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) dbnc_q <= '0;
        else       dbnc_q <= dbnc_d;
    end

    assign pin_val = f_q;

    function automatic logic [31:0] dbnc_rd();
        logic [31:0] r;
        r = '0;
        r[DBNC_W-1:0] = dbnc_q;
        return r;
    endfunction
`else
    assign pin_val = s2_q;

    function automatic logic [31:0] dbnc_rd();
        return 32'd0;
    endfunction
`endif

    // Edge events; prev tracks whatever feeds IN so edges and IN agree.
    assign ev_set = (pin_val & ~prev_q & rise_q) | (~pin_val & prev_q & fall_q);

    // ------------------------------------------------------------------
    // Register next-state
    // ------------------------------------------------------------------
    always_comb begin
        dir_d  = dir_q;
        out_d  = out_q;
        rise_d = rise_q;
        fall_d = fall_q;
        stat_d = stat_q;
        if (wr) begin
            case (paddr_i)
                A_DIR:   dir_d  = wdata;
                A_OUT:   out_d  = wdata;
                A_SET:   out_d  = out_q | wdata;
                A_CLR:   out_d  = out_q & ~wdata;
                A_RISE:  rise_d = wdata;
                A_FALL:  fall_d = wdata;
                A_STAT:  stat_d = stat_q & ~wdata;
                default: ;
            endcase
        end
        // A new event beats a same-cycle W1C clear of that bit.
        stat_d = stat_d | ev_set;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dir_q  <= '0;
            out_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
            stat_q <= '0;
            s1_q   <= '0;
            s2_q   <= '0;
            prev_q <= '0;
        end else begin
            dir_q  <= dir_d;
            out_q  <= out_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            stat_q <= stat_d;
            s1_q   <= gpio_in_i;
            s2_q   <= s1_q;
            prev_q <= pin_val;
        end
    end

    // ------------------------------------------------------------------
    // Read mux (combinational, zero outside a read access)
    // ------------------------------------------------------------------
    always_comb begin
        prdata_o = '0;
        if (rd) begin
            case (paddr_i)
                A_ID:    prdata_o = {24'd0, ID};
                A_DIR:   prdata_o = zext(dir_q);
                A_OUT:   prdata_o = zext(out_q);
                A_IN:    prdata_o = zext(pin_val);
                A_RISE:  prdata_o = zext(rise_q);
                A_FALL:  prdata_o = zext(fall_q);
                A_STAT:  prdata_o = zext(stat_q);
                A_DBNC:  prdata_o = dbnc_rd();
                default: prdata_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_user_ip_gpio_ctrl.sv
module tb_user_ip_gpio_ctrl;

    localparam int N = 8;
`ifdef USER_IP_GPIO_DEBOUNCE_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [7:0]    paddr = '0;
    logic [31:0]   pwdata = '0;
    logic [31:0]   prdata;
    logic          pready, pslverr;
    logic [N-1:0]  gpio_in = '0;
    logic [N-1:0]  gpio_out, gpio_oen;
    logic          irq;

    int n_vec = 0;
    int n_err = 0;

    user_ip_gpio_ctrl #(.ID(8'd255), .GPIO_NUM(N), .DBNC_W(16)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .psel_i     (psel),
        .penable_i  (penable),
        .pwrite_i   (pwrite),
        .paddr_i    (paddr),
        .pwdata_i   (pwdata),
        .prdata_o   (prdata),
        .pready_o   (pready),
        .pslverr_o  (pslverr),
        .gpio_in_i  (gpio_in),
        .gpio_out_o (gpio_out),
        .gpio_oen_o (gpio_oen),
        .irq_o      (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // All bus tasks start and end just after a falling edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic apb_wr(input logic [7:0] a, input logic [31:0] d);
        psel = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d; penable = 1'b0;
        @(posedge clk); @(negedge clk);
        penable = 1'b1;
        @(posedge clk); @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_rd(input logic [7:0] a, output logic [31:0] d);
        psel = 1'b1; pwrite = 1'b0; paddr = a; penable = 1'b0;
        @(posedge clk); @(negedge clk);
        penable = 1'b1;
        #1 d = prdata;
        @(posedge clk); @(negedge clk);
        psel = 1'b0; penable = 1'b0;
    endtask

    logic [31:0] rv;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        cyc(1);

        // Reset state
        apb_rd(8'h00, rv); chk("id", rv, 32'h0000_00FF);
        apb_rd(8'h04, rv); chk("dir_rst", rv, 32'h0);
        apb_rd(8'h08, rv); chk("out_rst", rv, 32'h0);
        apb_rd(8'h20, rv); chk("stat_rst", rv, 32'h0);
        chk("oen_rst", {24'd0, gpio_oen}, 32'hFF);
        chk("irq_rst", {31'd0, irq}, 32'h0);
        chk("pready", {31'd0, pready}, 32'h1);
        chk("pslverr", {31'd0, pslverr}, 32'h0);
        chk("prdata_idle", prdata, 32'h0);
        apb_rd(8'h40, rv); chk("unmapped", rv, 32'h0);

        // Direction and output set/clear
        apb_wr(8'h04, 32'hFFFF_FFF0);
        apb_wr(8'h08, 32'h0000_00A5);
        apb_wr(8'h0C, 32'h0000_0002);
        apb_wr(8'h10, 32'h0000_0080);
        chk("oen", {24'd0, gpio_oen}, 32'h0F);
        chk("gpio_out", {24'd0, gpio_out}, 32'h27);
        apb_rd(8'h0C, rv); chk("set_rd0", rv, 32'h0);
        apb_rd(8'h08, rv); chk("out_rd", rv, 32'h27);
        apb_rd(8'h04, rv); chk("dir_rd_masked", rv, 32'hF0);
        apb_wr(8'h24, 32'h0000_0005);
`ifdef USER_IP_GPIO_DEBOUNCE_EN
        apb_rd(8'h24, rv); chk("dbnc_rd", rv, 32'h5);
        apb_wr(8'h24, 32'h0);
`else
        apb_rd(8'h24, rv); chk("dbnc_rd", rv, 32'h0);
`endif

        // Rising edge on pin0: IN after k+1, STAT/irq at k+2
        apb_wr(8'h18, 32'h01);
        gpio_in[0] = 1'b1;           // before edge k
        cyc(1);                      // edge k
        chk("irq_k", {31'd0, irq}, 32'h0);
        cyc(LAT);
        apb_rd(8'h14, rv);           // access phase after k+1
        chk("in_k1", rv, 32'h01);
        chk("irq_k2", {31'd0, irq}, 32'h1);
        apb_rd(8'h20, rv); chk("stat_rise", rv, 32'h01);
        apb_wr(8'h20, 32'h01);
        chk("irq_w1c", {31'd0, irq}, 32'h0);
        apb_rd(8'h20, rv); chk("stat_w1c", rv, 32'h0);

        // Falling edge on pin2 vs simultaneous W1C
        apb_wr(8'h1C, 32'h04);
        gpio_in[2] = 1'b1;
        cyc(4);
        apb_rd(8'h20, rv); chk("stat_no_rise2", rv, 32'h0);
        gpio_in[2] = 1'b0;
        cyc(3 + LAT);
        apb_rd(8'h20, rv); chk("stat_fall", rv, 32'h04);
        gpio_in[2] = 1'b1;
        cyc(4);
        gpio_in[2] = 1'b0;           // set lands on the W1C write edge
        cyc(LAT);
        apb_wr(8'h20, 32'h04);
        apb_rd(8'h20, rv); chk("set_wins", rv, 32'h04);
        chk("irq_set_wins", {31'd0, irq}, 32'h1);
        apb_wr(8'h20, 32'h04);
        apb_rd(8'h20, rv); chk("stat_clr2", rv, 32'h0);

        // Disabling enables keeps STAT; then async reset mid-operation
        gpio_in[1:0] = 2'b00;
        cyc(4);
        apb_wr(8'h18, 32'h03);
        gpio_in[1:0] = 2'b11;
        cyc(3 + LAT);
        apb_wr(8'h18, 32'h00);
        apb_rd(8'h20, rv); chk("stat_03", rv, 32'h03);
        #2 rst = 1'b1;
        #1;
        chk("irq_async_rst", {31'd0, irq}, 32'h0);
        chk("out_async_rst", {24'd0, gpio_out}, 32'h0);
        chk("oen_async_rst", {24'd0, gpio_oen}, 32'hFF);
        @(negedge clk);
        rst = 1'b0;
        apb_rd(8'h20, rv); chk("stat_after_rst", rv, 32'h0);
        cyc(3);
        apb_rd(8'h14, rv); chk("in_after_rst", rv, 32'h03);
        chk("irq_after_rst", {31'd0, irq}, 32'h0);

`ifdef USER_IP_GPIO_DEBOUNCE_EN
        // Debounce: 2-clk glitch rejected, long hold accepted
        gpio_in[1] = 1'b0;
        cyc(6);
        apb_wr(8'h24, 32'd3);
        apb_wr(8'h18, 32'h02);
        gpio_in[1] = 1'b1;
        cyc(2);
        gpio_in[1] = 1'b0;
        cyc(6);
        apb_rd(8'h14, rv); chk("dbnc_glitch_in", rv & 32'h2, 32'h0);
        apb_rd(8'h20, rv); chk("dbnc_glitch_stat", rv, 32'h0);
        gpio_in[1] = 1'b1;
        cyc(8);
        apb_rd(8'h14, rv); chk("dbnc_hold_in", rv & 32'h2, 32'h2);
        apb_rd(8'h20, rv); chk("dbnc_hold_stat", rv, 32'h02);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
